// File: rtl/mem_stage_pkg.sv
// Shared datapath types for the MEM stage: word/register widths, the
// EX/MEM and MEM/WB pipeline latches, and the MEM stage FSM states.
package mem_stage_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    // Writeback source select carried down the pipe.
    typedef enum logic [1:0] {
        RS_ALU = 2'd0,
        RS_MEM = 2'd1,
        RS_LUI = 2'd2,
        RS_NPC = 2'd3
    } regsrc_t;

    // PC source select used by the fetch logic.
    typedef enum logic [1:0] {
        PC_NEXT   = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JR     = 2'd3
    } pcsrc_t;

    // MEM stage data-access state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } memstate_t;

    // EX/MEM latch; all-zero is a bubble.
    typedef struct packed {
        word_t    imemload;
        word_t    pc4;
        word_t    baddr;
        word_t    rdat2;
        word_t    alu_out;
        word_t    lui_ext;
        word_t    imm32;
        regbits_t regtbw;
        regsrc_t  regsrc;
        logic     regWEN;
        logic     dREN;
        logic     dWEN;
        logic     halt;
    } EX_MEM_t;

    // MEM/WB latch; imemload/pc4/npc/baddr/rdat2 only feed the cpu tracker.
    typedef struct packed {
        word_t    imemload;
        word_t    pc4;
        word_t    npc;
        word_t    baddr;
        word_t    rdat2;
        word_t    alu_out;
        word_t    lui_ext;
        word_t    imm32;
        word_t    dload;
        regbits_t regtbw;
        regsrc_t  regsrc;
        logic     regWEN;
        logic     halt;
    } MEM_WB_t;

endpackage

// File: rtl/mem_stage_if.sv
// Datapath-to-data-cache request/response bus.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;
    logic  dhit;
    word_t dmemload;

    // Pipeline side issues requests.
    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    // Cache side answers them.
    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: issues the data-cache access for
// the instruction in EX/MEM, stalls upstream until dhit, parks a hit that
// arrives while the pipe is frozen, and owns the sticky halt latch.
// Optional build macro: CPU_TRACKER_EN populates the tracker-only MEM/WB
// fields (imemload, pc4, npc, baddr, rdat2); otherwise they read zero.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  EX_MEM_t     ex_mem,
    input  word_t       npc,
    input  logic        pipe_en,
    mem_stage_if.master dbus,
    output logic        mem_stall,
    output MEM_WB_t     mem_wb,
    output logic        halt
);

    memstate_t state_q, state_d;
    MEM_WB_t   mem_wb_q, mem_wb_d;
    word_t     hold_q, hold_d;

    logic      mem_op;
    logic      req;
    MEM_WB_t   wb_fill;
    MEM_WB_t   wb_cand;
    logic      wb_load;

`ifndef CPU_TRACKER_EN
    logic      tracker_unused;
    assign tracker_unused = ^{ex_mem.imemload, ex_mem.pc4, ex_mem.baddr, npc};
`endif

    // Request generation; requests are forced low while reset is held.
    always_comb begin
        mem_op         = ex_mem.dREN | ex_mem.dWEN;
        req            = mem_op && ((state_q == IDLE) || (state_q == ACCESS));
        dbus.dmemREN   = req && ex_mem.dREN && !RST;
        dbus.dmemWEN   = req && ex_mem.dWEN && !ex_mem.dREN && !RST;
        dbus.dmemaddr  = ex_mem.alu_out;
        dbus.dmemstore = ex_mem.rdat2;
        mem_stall      = req && !dbus.dhit;
    end

    // MEM/WB image of the current EX/MEM instruction, load data left zero.
    always_comb begin
        wb_fill          = '0;
        wb_fill.regtbw   = ex_mem.regtbw;
        wb_fill.regsrc   = ex_mem.regsrc;
        wb_fill.regWEN   = ex_mem.regWEN;
        wb_fill.alu_out  = ex_mem.alu_out;
        wb_fill.lui_ext  = ex_mem.lui_ext;
        wb_fill.imm32    = ex_mem.imm32;
        wb_fill.halt     = ex_mem.halt;
`ifdef CPU_TRACKER_EN
        wb_fill.imemload = ex_mem.imemload;
        wb_fill.pc4      = ex_mem.pc4;
        wb_fill.npc      = npc;
        wb_fill.baddr    = ex_mem.baddr;
        wb_fill.rdat2    = ex_mem.rdat2;
`endif
    end

    // Next-state, hold register and MEM/WB load decisions.
    always_comb begin
        state_d  = state_q;
        mem_wb_d = mem_wb_q;
        hold_d   = hold_q;
        wb_cand  = wb_fill;
        wb_load  = 1'b0;

        case (state_q)
            IDLE, ACCESS: begin
                if (!req) begin
                    state_d = IDLE;
                    wb_load = pipe_en;
                end else if (dbus.dhit) begin
                    if (pipe_en) begin
                        state_d       = IDLE;
                        wb_cand.dload = dbus.dmemload;
                        wb_load       = 1'b1;
                    end else begin
                        // Hit landed while the pipe is frozen: park the data
                        // so the access is not reissued.
                        state_d = HOLD;
                        hold_d  = dbus.dmemload;
                    end
                end else begin
                    state_d = ACCESS;
                    if (pipe_en) begin
                        mem_wb_d = '0;
                    end
                end
            end
            HOLD: begin
                if (pipe_en) begin
                    state_d       = IDLE;
                    wb_cand.dload = hold_q;
                    wb_load       = 1'b1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (wb_load) begin
            mem_wb_d = wb_cand;
            if (wb_cand.halt) begin
                state_d = HALTED;
            end
        end
    end

    // State, hold data and MEM/WB latch registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            mem_wb_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            mem_wb_q <= mem_wb_d;
            hold_q   <= hold_d;
        end
    end

    assign mem_wb = mem_wb_q;
    assign halt   = mem_wb_q.halt;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// instruction stream scored against a transaction-level expectation.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic    CLK = 1'b0;
    logic    RST = 1'b1;
    EX_MEM_t ex_mem;
    word_t   npc;
    logic    pipe_en;
    logic    mem_stall;
    MEM_WB_t mem_wb;
    logic    halt;

    mem_stage_if dbus ();

    mem_stage dut (
        .CLK       (CLK),
        .RST       (RST),
        .ex_mem    (ex_mem),
        .npc       (npc),
        .pipe_en   (pipe_en),
        .dbus      (dbus),
        .mem_stall (mem_stall),
        .mem_wb    (mem_wb),
        .halt      (halt)
    );

    always #5 CLK = ~CLK;

    int      n_tests = 0;
    int      n_fail  = 0;
    MEM_WB_t exp_prev = '0;

    // kind: 0 = ALU, 1 = load, 2 = store
    function automatic EX_MEM_t rand_instr(input int kind);
        EX_MEM_t e;
        e          = '0;
        e.imemload = $urandom;
        e.pc4      = $urandom;
        e.baddr    = $urandom | 32'h1;
        e.rdat2    = $urandom | 32'h1;
        e.alu_out  = $urandom;
        e.lui_ext  = $urandom;
        e.imm32    = $urandom;
        e.regtbw   = 5'($urandom_range(1, 31));
        e.regsrc   = regsrc_t'(2'($urandom_range(0, 3)));
        e.regWEN   = 1'($urandom_range(0, 1));
        e.dREN     = (kind == 1);
        e.dWEN     = (kind == 2);
        e.halt     = 1'b0;
        return e;
    endfunction

    // What writeback should see for instruction e retiring with load data d.
    function automatic MEM_WB_t exp_wb(input EX_MEM_t e, input word_t d, input word_t n);
        MEM_WB_t w;
        w         = '0;
        w.regtbw  = e.regtbw;
        w.regsrc  = e.regsrc;
        w.regWEN  = e.regWEN;
        w.alu_out = e.alu_out;
        w.lui_ext = e.lui_ext;
        w.imm32   = e.imm32;
        w.halt    = e.halt;
        w.dload   = d;
`ifdef CPU_TRACKER_EN
        w.imemload = e.imemload;
        w.pc4      = e.pc4;
        w.npc      = n;
        w.baddr    = e.baddr;
        w.rdat2    = e.rdat2;
`else
        if (n == 32'hFFFF_FFFF) w.dload = d;
`endif
        return w;
    endfunction

    task automatic idle_inputs();
        @(negedge CLK);
        ex_mem        = '0;
        pipe_en       = 1'b0;
        dbus.dhit     = 1'b0;
        dbus.dmemload = '0;
    endtask

    task automatic test_reset();
        EX_MEM_t e;
        e = rand_instr(1);
        RST = 1'b1; ex_mem = e; pipe_en = 1'b1; npc = $urandom;
        dbus.dhit = 1'b1; dbus.dmemload = $urandom;
        @(posedge CLK); #1;
        n_tests++; if (mem_wb !== '0) begin n_fail++; $display("FAIL reset_mem_wb got=%h want=0", mem_wb); end
        n_tests++; if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt got=%b want=0", halt); end
        n_tests++; if (dbus.dmemREN !== 1'b0) begin n_fail++; $display("FAIL reset_dmemREN got=%b want=0", dbus.dmemREN); end
        @(negedge CLK);
        RST = 1'b0; ex_mem = '0; pipe_en = 1'b0; dbus.dhit = 1'b0;
        #1;
        n_tests++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b want=0", mem_stall); end
        exp_prev = '0;
        $display("[TB] reset done");
    endtask

    task automatic test_load_hit();
        EX_MEM_t e; word_t d; word_t n; MEM_WB_t want;
        e = rand_instr(1); e.alu_out = 32'h40; d = $urandom;
        @(negedge CLK);
        n = $urandom; ex_mem = e; pipe_en = 1'b1; npc = n; #1;
        n_tests++; if (dbus.dmemREN !== 1'b1 || dbus.dmemWEN !== 1'b0) begin n_fail++; $display("FAIL lw_hit_req got=%b%b want=10", dbus.dmemREN, dbus.dmemWEN); end
        n_tests++; if (dbus.dmemaddr !== 32'h40) begin n_fail++; $display("FAIL lw_hit_addr got=%h want=40", dbus.dmemaddr); end
        dbus.dhit = 1'b1; dbus.dmemload = d; #1;
        n_tests++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL lw_hit_stall got=%b want=0", mem_stall); end
        @(posedge CLK); #1;
        want = exp_wb(e, d, n);
        n_tests++; if (mem_wb !== want) begin n_fail++; $display("FAIL lw_hit_wb got=%h want=%h", mem_wb, want); end
        exp_prev = want;
        idle_inputs(); #1;
        n_tests++; if (dbus.dmemREN !== 1'b0) begin n_fail++; $display("FAIL lw_hit_req_drop got=%b want=0", dbus.dmemREN); end
        $display("[TB] lw hit addr=40 data=%h", d);
    endtask

    task automatic test_store_miss();
        EX_MEM_t e; word_t n; MEM_WB_t want;
        e = rand_instr(2); e.rdat2 = 32'hDEADBEEF;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            n = $urandom; ex_mem = e; pipe_en = 1'b1; npc = n; dbus.dhit = 1'b0; dbus.dmemload = '0; #1;
            n_tests++; if (dbus.dmemWEN !== 1'b1 || dbus.dmemREN !== 1'b0) begin n_fail++; $display("FAIL sw_req c=%0d got=%b%b want=01", c, dbus.dmemREN, dbus.dmemWEN); end
            n_tests++; if (dbus.dmemaddr !== e.alu_out || dbus.dmemstore !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_bus c=%0d got=%h/%h want=%h/deadbeef", c, dbus.dmemaddr, dbus.dmemstore, e.alu_out); end
            dbus.dhit = (c == 3); #1;
            n_tests++; if (mem_stall !== (c < 3)) begin n_fail++; $display("FAIL sw_stall c=%0d got=%b want=%b", c, mem_stall, (c < 3)); end
            @(posedge CLK); #1;
            want = (c < 3) ? MEM_WB_t'('0) : exp_wb(e, '0, n);
            n_tests++; if (mem_wb !== want) begin n_fail++; $display("FAIL sw_wb c=%0d got=%h want=%h", c, mem_wb, want); end
            exp_prev = want;
        end
        idle_inputs(); #1;
        n_tests++; if (dbus.dmemWEN !== 1'b0) begin n_fail++; $display("FAIL sw_req_drop got=%b want=0", dbus.dmemWEN); end
        $display("[TB] sw miss 3 cycles store=deadbeef");
    endtask

    task automatic test_load_hold();
        EX_MEM_t e; word_t d; word_t n; MEM_WB_t want;
        e = rand_instr(1); d = $urandom;
        @(negedge CLK);
        ex_mem = e; pipe_en = 1'b0; npc = $urandom; #1;
        n_tests++; if (dbus.dmemREN !== 1'b1) begin n_fail++; $display("FAIL hold_req got=%b want=1", dbus.dmemREN); end
        dbus.dhit = 1'b1; dbus.dmemload = d;
        @(posedge CLK); #1;
        n_tests++; if (mem_wb !== exp_prev) begin n_fail++; $display("FAIL hold_frozen got=%h want=%h", mem_wb, exp_prev); end
        @(negedge CLK);
        dbus.dhit = 1'b0; dbus.dmemload = ~d; #1;
        n_tests++; if (dbus.dmemREN !== 1'b0 || mem_stall !== 1'b0) begin n_fail++; $display("FAIL hold_quiet got=%b%b want=00", dbus.dmemREN, mem_stall); end
        @(posedge CLK); #1;
        n_tests++; if (mem_wb !== exp_prev) begin n_fail++; $display("FAIL hold_frozen2 got=%h want=%h", mem_wb, exp_prev); end
        @(negedge CLK);
        n = $urandom; pipe_en = 1'b1; npc = n; #1;
        n_tests++; if (dbus.dmemREN !== 1'b0) begin n_fail++; $display("FAIL hold_noreissue got=%b want=0", dbus.dmemREN); end
        @(posedge CLK); #1;
        want = exp_wb(e, d, n);
        n_tests++; if (mem_wb !== want) begin n_fail++; $display("FAIL hold_wb got=%h want=%h", mem_wb, want); end
        exp_prev = want;
        idle_inputs();
        $display("[TB] lw hit while frozen data=%h", d);
    endtask

    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            int      kind = $urandom_range(0, 3);
            int      lat  = $urandom_range(0, 3);
            int      cyc  = 0;
            bit      done;
            bit      retired = 1'b0;
            word_t   data = '0;
            EX_MEM_t e;
            e    = (kind == 3) ? EX_MEM_t'('0) : rand_instr(kind);
            done = !(e.dREN || e.dWEN);
            while (!retired && cyc < 64) begin
                bit      rq;
                MEM_WB_t want;
                @(negedge CLK);
                ex_mem = e; pipe_en = ($urandom_range(0, 3) != 0); npc = $urandom;
                dbus.dhit = 1'b0; dbus.dmemload = $urandom; #1;
                rq = !done;
                n_tests++; if (dbus.dmemREN !== (rq && e.dREN) || dbus.dmemWEN !== (rq && e.dWEN)) begin n_fail++; $display("FAIL rnd_req t=%0d got=%b%b want=%b%b", t, dbus.dmemREN, dbus.dmemWEN, rq && e.dREN, rq && e.dWEN); end
                if (rq) begin
                    n_tests++; if (dbus.dmemaddr !== e.alu_out || dbus.dmemstore !== e.rdat2) begin n_fail++; $display("FAIL rnd_bus t=%0d got=%h/%h want=%h/%h", t, dbus.dmemaddr, dbus.dmemstore, e.alu_out, e.rdat2); end
                    if (lat == 0) begin
                        dbus.dhit = 1'b1;
                        dbus.dmemload = e.dREN ? word_t'($urandom) : '0;
                        data = dbus.dmemload;
                        done = 1'b1;
                    end else begin
                        lat--;
                    end
                end
                #1;
                n_tests++; if (mem_stall !== (rq && !dbus.dhit)) begin n_fail++; $display("FAIL rnd_stall t=%0d got=%b want=%b", t, mem_stall, rq && !dbus.dhit); end
                if (pipe_en) begin
                    if (done) begin want = exp_wb(e, data, npc); retired = 1'b1; end
                    else want = '0;
                end else begin
                    want = exp_prev;
                end
                @(posedge CLK); #1;
                n_tests++; if (mem_wb !== want) begin n_fail++; $display("FAIL rnd_wb t=%0d got=%h want=%h", t, mem_wb, want); end
                exp_prev = want;
                cyc++;
            end
            n_tests++; if (!retired) begin n_fail++; $display("FAIL rnd_timeout t=%0d got=stuck want=retire", t); end
            $display("[TB] txn %0d kind=%0d cycles=%0d dload=%h", t, kind, cyc, data);
        end
        idle_inputs();
    endtask

    task automatic test_halt();
        EX_MEM_t s; EX_MEM_t h; word_t n; MEM_WB_t want;
        s = rand_instr(2);
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            n = $urandom; ex_mem = s; pipe_en = 1'b1; npc = n; dbus.dhit = (c == 1); dbus.dmemload = '0; #1;
            n_tests++; if (dbus.dmemWEN !== 1'b1) begin n_fail++; $display("FAIL halt_sw_req c=%0d got=%b want=1", c, dbus.dmemWEN); end
            @(posedge CLK); #1;
            want = (c == 0) ? MEM_WB_t'('0) : exp_wb(s, '0, n);
            n_tests++; if (mem_wb !== want || halt !== 1'b0) begin n_fail++; $display("FAIL halt_sw_wb c=%0d got=%h/%b want=%h/0", c, mem_wb, halt, want); end
            exp_prev = want;
        end
        h = rand_instr(0); h.halt = 1'b1;
        @(negedge CLK);
        n = $urandom; ex_mem = h; npc = n; dbus.dhit = 1'b0; #1;
        n_tests++; if (dbus.dmemWEN !== 1'b0 || dbus.dmemREN !== 1'b0) begin n_fail++; $display("FAIL halt_req got=%b%b want=00", dbus.dmemREN, dbus.dmemWEN); end
        @(posedge CLK); #1;
        want = exp_wb(h, '0, n);
        n_tests++; if (halt !== 1'b1 || mem_wb !== want) begin n_fail++; $display("FAIL halt_latch got=%b/%h want=1/%h", halt, mem_wb, want); end
        exp_prev = want;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            ex_mem = rand_instr(1); pipe_en = 1'b1; npc = $urandom; dbus.dhit = 1'b1; dbus.dmemload = $urandom; #1;
            n_tests++; if (dbus.dmemREN !== 1'b0 || mem_stall !== 1'b0) begin n_fail++; $display("FAIL halted_req c=%0d got=%b%b want=00", c, dbus.dmemREN, mem_stall); end
            @(posedge CLK); #1;
            n_tests++; if (mem_wb !== exp_prev || halt !== 1'b1) begin n_fail++; $display("FAIL halted_frozen c=%0d got=%h/%b want=%h/1", c, mem_wb, halt, exp_prev); end
        end
        $display("[TB] halt after store latched");
    endtask

    task automatic test_reset_mid_access();
        EX_MEM_t a; EX_MEM_t l; word_t n; word_t d; MEM_WB_t want;
        @(negedge CLK);
        RST = 1'b1; ex_mem = '0; pipe_en = 1'b0; dbus.dhit = 1'b0; #1;
        n_tests++; if (halt !== 1'b0) begin n_fail++; $display("FAIL rst_halt_clear got=%b want=0", halt); end
        @(negedge CLK);
        RST = 1'b0;
        a = rand_instr(0);
        @(negedge CLK);
        n = $urandom; ex_mem = a; pipe_en = 1'b1; npc = n;
        @(posedge CLK); #1;
        want = exp_wb(a, '0, n);
        n_tests++; if (mem_wb !== want) begin n_fail++; $display("FAIL rst_pre_wb got=%h want=%h", mem_wb, want); end
        l = rand_instr(1); d = $urandom;
        @(negedge CLK);
        ex_mem = l; pipe_en = 1'b0; npc = $urandom; #1;
        n_tests++; if (dbus.dmemREN !== 1'b1 || mem_stall !== 1'b1) begin n_fail++; $display("FAIL rst_access got=%b%b want=11", dbus.dmemREN, mem_stall); end
        @(posedge CLK); #2;
        RST = 1'b1; #1;
        n_tests++; if (dbus.dmemREN !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req got=%b want=0", dbus.dmemREN); end
        n_tests++; if (mem_wb !== '0 || halt !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wb got=%h/%b want=0/0", mem_wb, halt); end
        @(negedge CLK);
        RST = 1'b0; n = $urandom; npc = n; pipe_en = 1'b1; dbus.dhit = 1'b1; dbus.dmemload = d; #1;
        n_tests++; if (dbus.dmemREN !== 1'b1 || mem_stall !== 1'b0) begin n_fail++; $display("FAIL rst_after_req got=%b%b want=10", dbus.dmemREN, mem_stall); end
        @(posedge CLK); #1;
        want = exp_wb(l, d, n);
        n_tests++; if (mem_wb !== want) begin n_fail++; $display("FAIL rst_after_wb got=%h want=%h", mem_wb, want); end
        exp_prev = want;
        idle_inputs();
        $display("[TB] reset mid access recovered");
    endtask

    task automatic test_tracker_fields();
        EX_MEM_t e; word_t n;
        e = rand_instr(0);
        @(negedge CLK);
        n = $urandom | 32'h1; ex_mem = e; pipe_en = 1'b1; npc = n;
        @(posedge CLK); #1;
`ifdef CPU_TRACKER_EN
        n_tests++; if (mem_wb.baddr !== e.baddr || mem_wb.rdat2 !== e.rdat2 || mem_wb.npc !== n) begin n_fail++; $display("FAIL trk_fields got=%h/%h/%h want=%h/%h/%h", mem_wb.baddr, mem_wb.rdat2, mem_wb.npc, e.baddr, e.rdat2, n); end
`else
        n_tests++; if (mem_wb.baddr !== '0 || mem_wb.rdat2 !== '0 || mem_wb.npc !== '0) begin n_fail++; $display("FAIL trk_fields got=%h/%h/%h want=0/0/0", mem_wb.baddr, mem_wb.rdat2, mem_wb.npc); end
`endif
        n_tests++; if (mem_wb.regtbw !== e.regtbw || mem_wb.regWEN !== e.regWEN || mem_wb.dload !== '0) begin n_fail++; $display("FAIL trk_core got=%h/%b/%h want=%h/%b/0", mem_wb.regtbw, mem_wb.regWEN, mem_wb.dload, e.regtbw, e.regWEN); end
        exp_prev = exp_wb(e, '0, n);
        idle_inputs();
        $display("[TB] tracker field check regtbw=%0d", e.regtbw);
    endtask

    initial begin
        ex_mem = '0; npc = '0; pipe_en = 1'b0;
        dbus.dhit = 1'b0; dbus.dmemload = '0;
        test_reset();
        test_load_hit();
        test_store_miss();
        test_load_hold();
        test_tracker_fields();
        test_random();
        test_halt();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
